// File: rtl/ins_parcel_queue.sv
`default_nettype none
// ============================================================================
// Module      : ins_parcel_queue
// Description : Fetch-to-decode parcel buffer for the VC16 instruction stream.
//               It splits fetch words into 16-bit parcels, queues them with
//               their PC and fault tags, and pre-decodes branch/jump classes
//               on the head parcel.
//               Optional macro PARCEL_QUEUE_BYPASS_EN: when the queue is empty,
//               the first pushed parcel is presented to the decoder in the
//               same cycle it arrives.
// Revision    : 1.0 - initial release
// ============================================================================
module ins_parcel_queue #(
    parameter int FETCH_W = 32,
    parameter int DEPTH   = 8,
    parameter int RV      = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     fetch_valid,
    output logic                     fetch_ready,
    input  logic [FETCH_W-1:0]       fetch_data,
    input  logic [RV-1:0]            fetch_pc,
    input  logic                     fetch_fault,
    input  logic                     flush,
    output logic                     ins_valid,
    input  logic                     ins_ready,
    output logic [15:0]              ins,
    output logic [RV-1:0]            ins_pc,
    output logic                     ins_fault,
    output logic                     ins_br,
    output logic                     ins_jmp,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_NPARCEL = FETCH_W / 16;
    localparam int c_PW      = $clog2(DEPTH);
    localparam int c_CW      = c_PW + 1;

    localparam logic [c_CW-1:0] c_DEPTH_CW   = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_NPARCEL_CW = c_CW'(c_NPARCEL);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [15:0]      r_parcel [DEPTH];
    logic [RV-1:0]    r_pc     [DEPTH];
    logic             r_fault  [DEPTH];
    logic [c_PW-1:0]  r_wptr;
    logic [c_PW-1:0]  r_rptr;
    logic [c_CW-1:0]  r_count;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic             w_push;
    logic             w_qpop;
    logic             w_byp;
    logic             w_byp_take;
    logic [c_CW-1:0]  w_skip;
    logic [c_CW-1:0]  w_first;
    logic [c_CW-1:0]  w_nwr;
    logic [c_PW-1:0]  w_widx [c_NPARCEL];
    logic             w_wen  [c_NPARCEL];
    logic [RV-1:0]    w_wpc  [c_NPARCEL];

    logic             w_head_valid;
    logic [15:0]      w_head_parcel;
    logic [RV-1:0]    w_head_pc;
    logic             w_head_fault;

    // Leading parcels before the fetch PC are not part of the stream
    generate
        if (c_NPARCEL == 1) begin : g_skip_single
            assign w_skip = '0;
        end else begin : g_skip_multi
            assign w_skip = c_CW'(fetch_pc[$clog2(c_NPARCEL):1]);
        end
    endgenerate

    assign fetch_ready = (c_DEPTH_CW - r_count) >= c_NPARCEL_CW;
    assign w_push      = fetch_valid & fetch_ready & ~flush;
    assign w_qpop      = (r_count != '0) & ins_ready;
    assign w_byp_take  = w_byp & ins_ready;
    assign w_first     = w_skip + {{(c_CW-1){1'b0}}, w_byp_take};
    assign w_nwr       = c_NPARCEL_CW - w_first;

    always_comb begin
        for (int k = 0; k < c_NPARCEL; k++) begin
            w_widx[k] = r_wptr + c_PW'(k) - w_first[c_PW-1:0];
            w_wen[k]  = w_push & (c_CW'(k) >= w_first);
            w_wpc[k]  = fetch_pc + RV'((c_CW'(k) - w_skip) << 1);
        end
    end

`ifdef PARCEL_QUEUE_BYPASS_EN
    assign w_byp         = w_push & (r_count == '0);
    assign w_head_valid  = (r_count != '0) | w_byp;
    assign w_head_parcel = w_byp ? 16'(fetch_data >> {w_skip, 4'b0000})
                                 : r_parcel[r_rptr];
    assign w_head_pc     = w_byp ? fetch_pc    : r_pc[r_rptr];
    assign w_head_fault  = w_byp ? fetch_fault : r_fault[r_rptr];
`else
    assign w_byp         = 1'b0;
    assign w_head_valid  = (r_count != '0);
    assign w_head_parcel = r_parcel[r_rptr];
    assign w_head_pc     = r_pc[r_rptr];
    assign w_head_fault  = r_fault[r_rptr];
`endif

    // ------------------------------------------------------------------------
    // Pointers and occupancy; flush outranks any push or pop
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + w_nwr[c_PW-1:0];
            end
            if (w_qpop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= r_count + (w_push ? w_nwr : '0)
                               - {{c_PW{1'b0}}, w_qpop};
        end
    end

    // Storage needs no reset: empty-queue outputs are masked below
    always_ff @(posedge clk) begin
        for (int k = 0; k < c_NPARCEL; k++) begin
            if (w_wen[k]) begin
                r_parcel[w_widx[k]] <= fetch_data[16*k +: 16];
                r_pc[w_widx[k]]     <= w_wpc[k];
                r_fault[w_widx[k]]  <= fetch_fault;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Pre-decode
    // ------------------------------------------------------------------------
    function automatic logic f_is_br(input logic [15:0] p);
        logic w_c1;
        w_c1 = (p[1:0] == 2'b01) &&
               ((p[15:13] == 3'b001) || (p[15:13] == 3'b101) ||
                (p[15:13] == 3'b110) || (p[15:13] == 3'b111));
        return w_c1 || ((p[1:0] == 2'b11) && (p[15:14] == 2'b11));
    endfunction

    function automatic logic f_is_jmp(input logic [15:0] p);
        return (p[1:0] == 2'b10) && (p[15:13] == 3'b100) &&
               (p[6:2] == 5'd0) && (p[11:7] != 5'd0);
    endfunction

    assign ins_valid = w_head_valid;
    assign ins       = w_head_valid ? w_head_parcel : '0;
    assign ins_pc    = w_head_valid ? w_head_pc     : '0;
    assign ins_fault = w_head_valid & w_head_fault;
    assign ins_br    = w_head_valid & ~w_head_fault & f_is_br(w_head_parcel);
    assign ins_jmp   = w_head_valid & ~w_head_fault & f_is_jmp(w_head_parcel);
    assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_ins_parcel_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_ins_parcel_queue
// Description : Randomised scoreboard bench for ins_parcel_queue against a
//               queue-based reference model of the parcel stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ins_parcel_queue;

    localparam int FETCH_W = 32;
    localparam int DEPTH   = 8;
    localparam int RV      = 32;
    localparam int P       = FETCH_W / 16;

    logic               clk;
    logic               reset_n;
    logic               fetch_valid;
    logic               fetch_ready;
    logic [FETCH_W-1:0] fetch_data;
    logic [RV-1:0]      fetch_pc;
    logic               fetch_fault;
    logic               flush;
    logic               ins_valid;
    logic               ins_ready;
    logic [15:0]        ins;
    logic [RV-1:0]      ins_pc;
    logic               ins_fault;
    logic               ins_br;
    logic               ins_jmp;
    logic [$clog2(DEPTH):0] count;

    ins_parcel_queue #(.FETCH_W(FETCH_W), .DEPTH(DEPTH), .RV(RV)) dut (
        .clk(clk), .reset_n(reset_n),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_data(fetch_data), .fetch_pc(fetch_pc), .fetch_fault(fetch_fault),
        .flush(flush),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins),
        .ins_pc(ins_pc), .ins_fault(ins_fault), .ins_br(ins_br),
        .ins_jmp(ins_jmp), .count(count)
    );

    typedef struct {
        logic [15:0]   parcel;
        logic [RV-1:0] pc;
        logic          fault;
    } ent_t;

    ent_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Branch class: c.jal, c.j, c.beqz, c.bnez, or a 32-bit-style parcel in the jump space
    function automatic logic ref_br(input logic [15:0] p);
        int quad = p[1:0];
        int f3   = p[15:13];
        if (quad == 1 && (f3 == 1 || f3 == 5 || f3 == 6 || f3 == 7)) return 1'b1;
        if (quad == 3 && p[15:14] == 2'b11) return 1'b1;
        return 1'b0;
    endfunction

    // Register jump: c.jr / c.jalr with a non-zero rs1 and no rs2
    function automatic logic ref_jmp(input logic [15:0] p);
        return (p[1:0] == 2'b10) && (p[15:13] == 3'b100) &&
               (p[6:2] == 0) && (p[11:7] != 0);
    endfunction

    // Monitor: compare the DUT against the model, then advance the model
    always @(negedge clk) begin
        int   n;
        int   skip;
        logic rdy;
        ent_t e;
        if (!reset_n) begin
            exp_q.delete();
        end else begin
            n   = exp_q.size();
            rdy = (DEPTH - n) >= P;
            chk("count", 64'(count), 64'(n));
            chk("ins_valid", 64'(ins_valid), 64'(n != 0));
            chk("fetch_ready", 64'(fetch_ready), 64'(rdy));
            if (n != 0) begin
                chk("ins", 64'(ins), 64'(exp_q[0].parcel));
                chk("ins_pc", 64'(ins_pc), 64'(exp_q[0].pc));
                chk("ins_fault", 64'(ins_fault), 64'(exp_q[0].fault));
                chk("ins_br", 64'(ins_br), 64'(!exp_q[0].fault && ref_br(exp_q[0].parcel)));
                chk("ins_jmp", 64'(ins_jmp), 64'(!exp_q[0].fault && ref_jmp(exp_q[0].parcel)));
            end
            if (flush) begin
                exp_q.delete();
            end else begin
                if (n != 0 && ins_ready) void'(exp_q.pop_front());
                if (fetch_valid && rdy) begin
                    skip = (fetch_pc / 2) % P;
                    for (int k = skip; k < P; k++) begin
                        e.parcel = fetch_data[16*k +: 16];
                        e.pc     = fetch_pc + RV'(2 * (k - skip));
                        e.fault  = fetch_fault;
                        exp_q.push_back(e);
                    end
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [FETCH_W-1:0] d, input logic [RV-1:0] pc,
                         input logic f, input logic r, input logic fl);
        fetch_valid = v;
        fetch_data  = d;
        fetch_pc    = pc;
        fetch_fault = f;
        ins_ready   = r;
        flush       = fl;
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_count"}, 64'(count), 64'd0);
        chk({tag, "_ins_valid"}, 64'(ins_valid), 64'd0);
        chk({tag, "_fetch_ready"}, 64'(fetch_ready), 64'd1);
        chk({tag, "_ins"}, 64'(ins), 64'd0);
        chk({tag, "_ins_pc"}, 64'(ins_pc), 64'd0);
        chk({tag, "_ins_fault"}, 64'(ins_fault), 64'd0);
        chk({tag, "_ins_br"}, 64'(ins_br), 64'd0);
        chk({tag, "_ins_jmp"}, 64'(ins_jmp), 64'd0);
    endtask

    function automatic logic [15:0] rand_parcel();
        logic [15:0] pool [8];
        pool = '{16'hA001, 16'h8082, 16'h4505, 16'h0001,
                 16'hC001, 16'h9002, 16'h8002, 16'hFFFF};
        if ($urandom_range(0, 1) == 0) return pool[$urandom_range(0, 7)];
        return 16'($urandom);
    endfunction

    initial begin
        reset_n     = 1'b0;
        fetch_valid = 1'b0;
        fetch_data  = '0;
        fetch_pc    = '0;
        fetch_fault = 1'b0;
        ins_ready   = 1'b0;
        flush       = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // Aligned word with immediate consumption
        drive(1, {16'h4505, 16'h0001}, 32'h100, 0, 1, 0);
        repeat (3) drive(0, '0, '0, 0, 1, 0);

        // Misaligned start: only the upper parcel (c.jr ra) is queued
        drive(1, {16'h8082, 16'h1234}, 32'h102, 0, 0, 0);
        drive(0, '0, '0, 0, 0, 0);
        drive(0, '0, '0, 0, 1, 0);

        // Fill to capacity, offer extra words, then drain to count 5
        for (int i = 0; i < 6; i++)
            drive(1, {rand_parcel(), rand_parcel()}, 32'h200 + 32'(4 * i), 0, 0, 0);
        repeat (3) drive(0, '0, '0, 0, 1, 0);

        // Flush together with push and pop
        drive(1, {16'h1111, 16'h2222}, 32'h280, 0, 1, 1);
        drive(0, '0, '0, 0, 0, 0);

        // Faulted jump followed by a clean one
        drive(1, {16'h0001, 16'hA001}, 32'h300, 1, 0, 0);
        drive(1, {16'h0001, 16'hA001}, 32'h304, 0, 0, 0);
        drive(0, '0, '0, 0, 0, 0);
        repeat (5) drive(0, '0, '0, 0, 1, 0);

        // Asynchronous reset with three parcels queued and a fetch pending
        drive(1, {16'h3333, 16'h4444}, 32'h402, 0, 0, 0);
        drive(1, {16'h5555, 16'h6666}, 32'h404, 0, 0, 0);
        drive(0, '0, '0, 0, 0, 0);
        fetch_valid = 1'b1;
        fetch_data  = {16'h7777, 16'h8888};
        fetch_pc    = 32'h408;
        reset_n     = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk); #2;
        reset_n = 1'b1;
        drive(1, {16'h9999, 16'hAAAA}, 32'h500, 0, 0, 0);
        drive(0, '0, '0, 0, 1, 0);
        drive(0, '0, '0, 0, 1, 0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) < 6,
                  {rand_parcel(), rand_parcel()},
                  $urandom & 32'hFFFF_FFFE,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 9) < 6,
                  $urandom_range(0, 19) == 0);
        end
        repeat (10) drive(0, '0, '0, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
